mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 90 +++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers around a 256x16 data memory.
// Optional MEM_BOUNDS_CHECK_EN: accesses with a nonzero high address byte are
// blocked, read as 0, and flagged on addr_fault; otherwise addresses wrap mod 256.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic [15:0] ALU_out_E,
    input  logic [15:0] Data_Write_E,
    input  logic        MemRead_E,
    input  logic        MemWrite_E,
    input  logic        RegWrite_E,
    input  logic        MemToReg_E,
    input  logic [3:0]  Dest_E,
    output logic [15:0] ALU_out_MtoE,
    output logic [15:0] Write_back,
    output logic        RegWrite_M,
    output logic        MemRead_M,
    output logic [3:0]  Dest_M,
    output logic        RegWrite_W,
    output logic [3:0]  Dest_W,
    output logic        addr_fault
);
    logic [15:0] alu_m, wdata_m, alu_w, data_w, rdata;
    logic        memwrite_m, memtoreg_m, memtoreg_w, fault, we;
    logic [7:0]  addr;
    logic [15:0] mem [256];

    assign addr = alu_m[7:0];
`ifdef MEM_BOUNDS_CHECK_EN
    logic fault_w;
    assign fault = (MemRead_M | memwrite_m) & (|alu_m[15:8]);
    assign addr_fault = fault_w;
    // Fault flag travels with the access into W and is held under freeze.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            fault_w <= 1'b0;
        else if (!freeze)
            fault_w <= fault;
`else
    assign fault = 1'b0;
    assign addr_fault = 1'b0;
`endif
    assign we = memwrite_m & ~freeze & ~fault;
    assign rdata = fault ? 16'h0000 : mem[addr];
    assign ALU_out_MtoE = alu_m;
    assign Write_back = memtoreg_w ? data_w : alu_w;

    // EX/MEM register: freeze holds, flush turns the incoming op into a bubble.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            alu_m      <= '0;
            wdata_m    <= '0;
            MemRead_M  <= 1'b0;
            memwrite_m <= 1'b0;
            RegWrite_M <= 1'b0;
            memtoreg_m <= 1'b0;
            Dest_M     <= '0;
        end else if (!freeze) begin
            alu_m      <= ALU_out_E;
            wdata_m    <= Data_Write_E;
            MemRead_M  <= MemRead_E & ~flush;
            memwrite_m <= MemWrite_E & ~flush;
            RegWrite_M <= RegWrite_E & ~flush;
            memtoreg_m <= MemToReg_E & ~flush;
            Dest_M     <= Dest_E;
        end

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk)
        if (we)
            mem[addr] <= wdata_m;

    // MEM/WB register: the synchronous memory read lands here as M advances to W.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            alu_w      <= '0;
            data_w     <= '0;
            RegWrite_W <= 1'b0;
            memtoreg_w <= 1'b0;
            Dest_W     <= '0;
        end else if (!freeze) begin
            alu_w      <= alu_m;
            data_w     <= rdata;
            RegWrite_W <= RegWrite_M;
            memtoreg_w <= memtoreg_m;
            Dest_W     <= Dest_M;
        end
endmodule
